gray_stream_frame_arbiter: RTL and testbench
============================================

# gray_stream_frame_arbiter

Frame-granular arbiter that shares one grayscale-to-RGB format converter between the left and right camera grayscale AXI4-Stream inputs of the stereovision pipeline. It grants the converter's input to one camera for a whole frame, from the start-of-frame beat through the last line, then re-arbitrates round-robin. Stray beats that arrive between frames are flushed, and frame completion is reported on a status pulse.

## Interface
- DATA_WIDTH, 8, pixel data width
- PPC, 4, pixels per clock
- LINES_W, 12, width of the lines-per-frame configuration and the line counter

- aclk  in  1  clock; all logic is on the rising edge
- aresetn  in  1  asynchronous, active-low reset (one clock, async active-low reset: fixed)
- cfg_frame_lines  in  LINES_W  lines per frame; sampled only in IDLE; 0 is treated as 1
- s_axis_left_tvalid / tdata / tuser / tlast  in  1 / DATA_WIDTH*PPC / 1 / 1  left gray stream
- s_axis_left_tready  out  1
- s_axis_right_tvalid / tdata / tuser / tlast  in  1 / DATA_WIDTH*PPC / 1 / 1  right gray stream
- s_axis_right_tready  out  1
- m_axis_gray_tvalid / tdata / tuser / tlast  out  1 / DATA_WIDTH*PPC / 1 / 1  stream to the converter
- m_axis_gray_tready  in  1
- m_axis_gray_tdest  out  1  source of the current frame: 0 = left, 1 = right
- frame_done  out  1  one-cycle pulse after the last line of a frame completes
- drop_cnt  out  16  saturating count of flushed beats

## Operation
- States: IDLE, GRANT_L, GRANT_R. Reset state is IDLE. The priority pointer resets to left.
- IDLE behaviour:
  - m_axis_gray_tvalid = 0.
  - A stream presenting tvalid=1 with tuser=0 gets tready=1 and its beat is discarded. drop_cnt increments once per discarded beat and saturates at 0xFFFF. If both streams discard in the same cycle, drop_cnt increments by 2, still saturating.
  - A stream presenting tvalid=1 with tuser=1 gets tready=0; the SOF beat is held, not consumed.
  - If exactly one stream is presenting SOF, grant that stream.
  - If both are presenting SOF, grant the stream named by the priority pointer.
  - On grant: latch cfg_frame_lines (max(cfg,1)) into lines_reg, clear line_cnt, set tdest.
- GRANT_x behaviour:
  - m_axis_gray tdata/tuser/tlast/tvalid follow stream x combinationally.
  - s_axis_x_tready = m_axis_gray_tready.
  - The other stream's tready = 0.
- A line ends on a handshake (tvalid & tready) with tlast=1.
  - If line_cnt == lines_reg-1, the frame ends: go to IDLE, point priority at the other stream, and pulse frame_done on the next cycle.
  - Otherwise line_cnt++.
- tuser=1 seen mid-frame is passed through unchanged; the arbiter does not resynchronise.
- line_cnt is LINES_W wide and never wraps, because the frame ends at lines_reg-1.
- Reset mid-frame returns to IDLE immediately and asynchronously, with all counters and the pointer cleared. The downstream converter sees tvalid drop to 0.

## Timing
- Reset values:
  - m_axis_gray_tvalid = 0
  - s_axis_*_tready = 0
  - tdest = 0
  - frame_done = 0
  - drop_cnt = 0
  - m_axis tdata/tuser/tlast = 0 while in IDLE
- Data path latency through the arbiter is 0 cycles (combinational mux). Only the state, counters, tdest, pointer, frame_done and drop_cnt are registered.
- Grant latency: SOF valid at IDLE cycle t gives the grant state at t+1. At t+1 the SOF beat appears on m_axis.
- Frame turnaround:
  - Final tlast handshake at cycle t puts the state in IDLE at t+1, with frame_done=1 at t+1.
  - The earliest next grant is at t+2, so there is exactly one bubble cycle between frames.
- AXI rule: m_axis_gray_tvalid must never depend on m_axis_gray_tready. It depends only on the state and the selected s tvalid.
- tdest is stable for the whole granted frame and holds its value through IDLE.

## Test plan
- cfg=2, left sends a 2-line frame of 4 beats per line with m_tready=1:
  - the SOF beat is output at t+1 and tdest=0;
  - all 8 beats pass in order;
  - frame_done pulses once, one cycle after the second tlast.
- Both streams present SOF at the same time after reset, cfg=1:
  - left is granted first, right is held with tready=0;
  - right is granted exactly 2 cycles after left's tlast with tdest=1;
  - the next simultaneous SOF goes to left.
- Right sends 3 beats with tuser=0 while IDLE: all 3 are accepted and discarded, m_tvalid stays 0, drop_cnt=3.
- Random m_tready backpressure (50%) during a left frame of 3 lines:
  - every beat arrives exactly once, with no duplication or loss;
  - s_left_tready mirrors m_tready;
  - right tready stays 0 throughout.
- cfg_frame_lines=0: one line ends the frame.
- cfg changed to 5 mid-frame (lines_reg=2): the current frame still ends after 2 lines.
- aresetn asserted mid-line during a right frame:
  - m_tvalid, tready and tdest go to 0 immediately;
  - after release, a new left SOF is granted normally.

Source files
------------

// File: rtl/gray_stream_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gray_stream_frame_arbiter
// Brief    : Frame-granular round-robin arbiter sharing one gray-to-RGB
//            converter between the left and right camera AXI4-Stream inputs.
// Revision : 1.0
// ============================================================================
module gray_stream_frame_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int PPC        = 4,
    parameter int LINES_W    = 12
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [LINES_W-1:0]         cfg_frame_lines,

    input  logic                       s_axis_left_tvalid,
    input  logic [DATA_WIDTH*PPC-1:0]  s_axis_left_tdata,
    input  logic                       s_axis_left_tuser,
    input  logic                       s_axis_left_tlast,
    output logic                       s_axis_left_tready,

    input  logic                       s_axis_right_tvalid,
    input  logic [DATA_WIDTH*PPC-1:0]  s_axis_right_tdata,
    input  logic                       s_axis_right_tuser,
    input  logic                       s_axis_right_tlast,
    output logic                       s_axis_right_tready,

    output logic                       m_axis_gray_tvalid,
    output logic [DATA_WIDTH*PPC-1:0]  m_axis_gray_tdata,
    output logic                       m_axis_gray_tuser,
    output logic                       m_axis_gray_tlast,
    input  logic                       m_axis_gray_tready,
    output logic                       m_axis_gray_tdest,

    output logic                       frame_done,
    output logic [15:0]                drop_cnt
);

    localparam logic [1:0]         c_IDLE     = 2'd0;
    localparam logic [1:0]         c_GRANT_L  = 2'd1;
    localparam logic [1:0]         c_GRANT_R  = 2'd2;
    localparam logic [LINES_W-1:0] c_LINE_ONE = LINES_W'(1);

    logic [1:0]         r_state;
    logic               r_ptr;          // 0 = left has priority, 1 = right
    logic               r_tdest;
    logic [LINES_W-1:0] r_lines;
    logic [LINES_W-1:0] r_line_cnt;
    logic               r_frame_done;
    logic [15:0]        r_drop_cnt;

    logic               w_idle;
    logic               w_left_sof;
    logic               w_right_sof;
    logic               w_left_drop;
    logic               w_right_drop;
    logic               w_grant_l;
    logic               w_grant_r;
    logic [LINES_W-1:0] w_cfg_lines;
    logic               w_line_end;
    logic               w_last_line;
    logic [1:0]         w_drop_inc;
    logic [16:0]        w_drop_sum;
    logic [15:0]        w_drop_next;

    assign w_idle       = (r_state == c_IDLE);
    assign w_left_sof   = s_axis_left_tvalid  &  s_axis_left_tuser;
    assign w_right_sof  = s_axis_right_tvalid &  s_axis_right_tuser;
    assign w_left_drop  = w_idle & s_axis_left_tvalid  & ~s_axis_left_tuser;
    assign w_right_drop = w_idle & s_axis_right_tvalid & ~s_axis_right_tuser;

    assign w_grant_l = w_idle & w_left_sof & (~w_right_sof | ~r_ptr);
    assign w_grant_r = w_idle & w_right_sof & ~w_grant_l;

    assign w_cfg_lines = (cfg_frame_lines == '0) ? c_LINE_ONE : cfg_frame_lines;

    assign w_line_end  = m_axis_gray_tvalid & m_axis_gray_tready & m_axis_gray_tlast;
    assign w_last_line = (r_line_cnt == (r_lines - c_LINE_ONE));

    assign w_drop_inc  = {1'b0, w_left_drop} + {1'b0, w_right_drop};
    assign w_drop_sum  = {1'b0, r_drop_cnt} + {15'd0, w_drop_inc};
    assign w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

    // Pure combinational mux; tvalid never looks at the downstream tready.
    // Stray-beat readies are gated by reset so nothing is accepted while held.
    always_comb begin
        m_axis_gray_tvalid  = 1'b0;
        m_axis_gray_tdata   = '0;
        m_axis_gray_tuser   = 1'b0;
        m_axis_gray_tlast   = 1'b0;
        s_axis_left_tready  = 1'b0;
        s_axis_right_tready = 1'b0;
        case (r_state)
            c_IDLE: begin
                s_axis_left_tready  = w_left_drop  & aresetn;
                s_axis_right_tready = w_right_drop & aresetn;
            end
            c_GRANT_L: begin
                m_axis_gray_tvalid = s_axis_left_tvalid;
                m_axis_gray_tdata  = s_axis_left_tdata;
                m_axis_gray_tuser  = s_axis_left_tuser;
                m_axis_gray_tlast  = s_axis_left_tlast;
                s_axis_left_tready = m_axis_gray_tready;
            end
            c_GRANT_R: begin
                m_axis_gray_tvalid  = s_axis_right_tvalid;
                m_axis_gray_tdata   = s_axis_right_tdata;
                m_axis_gray_tuser   = s_axis_right_tuser;
                m_axis_gray_tlast   = s_axis_right_tlast;
                s_axis_right_tready = m_axis_gray_tready;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= c_IDLE;
            r_ptr        <= 1'b0;
            r_tdest      <= 1'b0;
            r_lines      <= c_LINE_ONE;
            r_line_cnt   <= '0;
            r_frame_done <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_drop_cnt   <= w_drop_next;
            case (r_state)
                c_IDLE: begin
                    if (w_grant_l || w_grant_r) begin
                        r_state    <= w_grant_l ? c_GRANT_L : c_GRANT_R;
                        r_tdest    <= w_grant_r;
                        r_lines    <= w_cfg_lines;
                        r_line_cnt <= '0;
                    end
                end
                c_GRANT_L, c_GRANT_R: begin
                    if (w_line_end) begin
                        if (w_last_line) begin
                            r_state      <= c_IDLE;
                            r_ptr        <= (r_state == c_GRANT_L);
                            r_frame_done <= 1'b1;
                        end else begin
                            r_line_cnt <= r_line_cnt + c_LINE_ONE;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign m_axis_gray_tdest = r_tdest;
    assign frame_done        = r_frame_done;
    assign drop_cnt          = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gray_stream_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_stream_frame_arbiter
// Brief    : Directed self-checking bench for gray_stream_frame_arbiter.
// Revision : 1.0
// ============================================================================
module tb_gray_stream_frame_arbiter;

    localparam int DW = 8;
    localparam int PP = 4;
    localparam int LW = 12;
    localparam int TW = DW * PP;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [LW-1:0] cfg_frame_lines;
    logic          l_tvalid, l_tuser, l_tlast, l_tready;
    logic [TW-1:0] l_tdata;
    logic          r_tvalid, r_tuser, r_tlast, r_tready;
    logic [TW-1:0] r_tdata;
    logic          m_tvalid, m_tuser, m_tlast, m_tready, m_tdest;
    logic [TW-1:0] m_tdata;
    logic          frame_done;
    logic [15:0]   drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    gray_stream_frame_arbiter #(.DATA_WIDTH(DW), .PPC(PP), .LINES_W(LW)) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .cfg_frame_lines     (cfg_frame_lines),
        .s_axis_left_tvalid  (l_tvalid),
        .s_axis_left_tdata   (l_tdata),
        .s_axis_left_tuser   (l_tuser),
        .s_axis_left_tlast   (l_tlast),
        .s_axis_left_tready  (l_tready),
        .s_axis_right_tvalid (r_tvalid),
        .s_axis_right_tdata  (r_tdata),
        .s_axis_right_tuser  (r_tuser),
        .s_axis_right_tlast  (r_tlast),
        .s_axis_right_tready (r_tready),
        .m_axis_gray_tvalid  (m_tvalid),
        .m_axis_gray_tdata   (m_tdata),
        .m_axis_gray_tuser   (m_tuser),
        .m_axis_gray_tlast   (m_tlast),
        .m_axis_gray_tready  (m_tready),
        .m_axis_gray_tdest   (m_tdest),
        .frame_done          (frame_done),
        .drop_cnt            (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic settle;
        @(negedge aclk);
    endtask

    task automatic drive_left(input logic v, input logic [TW-1:0] d, input logic u, input logic l);
        l_tvalid = v; l_tdata = d; l_tuser = u; l_tlast = l;
    endtask

    task automatic drive_right(input logic v, input logic [TW-1:0] d, input logic u, input logic l);
        r_tvalid = v; r_tdata = d; r_tuser = u; r_tlast = l;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int cyc;

        // ---------------- reset values (stray beat presented while in reset)
        aresetn = 1'b0;
        cfg_frame_lines = '0;
        m_tready = 1'b0;
        drive_left(1'b1, 32'h11, 1'b0, 1'b0);
        drive_right(1'b0, '0, 1'b0, 1'b0);
        settle;
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_ltready", l_tready, 0);
        chk("rst_rtready", r_tready, 0);
        chk("rst_tdest", m_tdest, 0);
        chk("rst_fdone", frame_done, 0);
        chk("rst_dropcnt", drop_cnt, 0);
        chk("rst_mdata", m_tdata, 0);
        chk("rst_muser", m_tuser, 0);
        chk("rst_mlast", m_tlast, 0);
        tick;
        aresetn = 1'b1;
        m_tready = 1'b1;
        cfg_frame_lines = 12'd2;

        // ---------------- left 2-line frame, 4 beats per line
        drive_left(1'b1, 32'hA000_0000, 1'b1, 1'b0);
        settle;
        chk("t1_sof_held", l_tready, 0);
        chk("t1_idle_mvalid", m_tvalid, 0);
        tick;
        for (int i = 0; i < 8; i++) begin
            drive_left(1'b1, 32'hA000_0000 + i, (i == 0), (i % 4 == 3));
            settle;
            chk("t1_mvalid", m_tvalid, 1);
            chk("t1_mdata", m_tdata, 32'hA000_0000 + i);
            chk("t1_muser", m_tuser, (i == 0));
            chk("t1_mlast", m_tlast, (i % 4 == 3));
            chk("t1_tdest", m_tdest, 0);
            chk("t1_ltready", l_tready, 1);
            chk("t1_fdone_mid", frame_done, 0);
            tick;
        end
        drive_left(1'b0, '0, 1'b0, 1'b0);
        settle;
        chk("t1_fdone", frame_done, 1);
        chk("t1_end_mvalid", m_tvalid, 0);
        chk("t1_end_mdata", m_tdata, 0);
        tick;
        settle;
        chk("t1_fdone_once", frame_done, 0);

        // ---------------- simultaneous SOF after reset, cfg=1
        aresetn = 1'b0;
        tick;
        aresetn = 1'b1;
        cfg_frame_lines = 12'd1;
        drive_left(1'b1, 32'hB0, 1'b1, 1'b0);
        drive_right(1'b1, 32'hC0, 1'b1, 1'b1);
        settle;
        chk("t2_idle_ltready", l_tready, 0);
        chk("t2_idle_rtready", r_tready, 0);
        chk("t2_idle_mvalid", m_tvalid, 0);
        tick;
        settle;
        chk("t2_grant_l_tdest", m_tdest, 0);
        chk("t2_grant_l_data", m_tdata, 32'hB0);
        chk("t2_r_held", r_tready, 0);
        chk("t2_l_ready", l_tready, 1);
        tick;
        drive_left(1'b1, 32'hB1, 1'b0, 1'b1);
        settle;
        chk("t2_l_last_data", m_tdata, 32'hB1);
        chk("t2_l_last_tlast", m_tlast, 1);
        chk("t2_r_held2", r_tready, 0);
        tick;
        drive_left(1'b0, '0, 1'b0, 1'b0);
        settle;
        chk("t2_bubble_mvalid", m_tvalid, 0);
        chk("t2_bubble_fdone", frame_done, 1);
        chk("t2_bubble_rtready", r_tready, 0);
        tick;
        settle;
        chk("t2_grant_r_mvalid", m_tvalid, 1);
        chk("t2_grant_r_tdest", m_tdest, 1);
        chk("t2_grant_r_data", m_tdata, 32'hC0);
        chk("t2_grant_r_rtready", r_tready, 1);
        tick;
        drive_left(1'b1, 32'hB2, 1'b1, 1'b1);
        drive_right(1'b1, 32'hC1, 1'b1, 1'b0);
        settle;
        chk("t2_tdest_hold_idle", m_tdest, 1);
        chk("t2_idle2_mvalid", m_tvalid, 0);
        tick;
        settle;
        chk("t2_rr_left_tdest", m_tdest, 0);
        chk("t2_rr_left_data", m_tdata, 32'hB2);
        chk("t2_rr_r_held", r_tready, 0);
        tick;
        drive_left(1'b0, '0, 1'b0, 1'b0);
        drive_right(1'b0, '0, 1'b0, 1'b0);
        settle;
        chk("t2_end_fdone", frame_done, 1);
        tick;

        // ---------------- stray beats flushed in IDLE
        for (int i = 0; i < 3; i++) begin
            drive_right(1'b1, 32'hD0 + i, 1'b0, 1'b0);
            settle;
            chk("t3_drop_rtready", r_tready, 1);
            chk("t3_drop_mvalid", m_tvalid, 0);
            tick;
        end
        drive_right(1'b0, '0, 1'b0, 1'b0);
        settle;
        chk("t3_dropcnt3", drop_cnt, 3);
        tick;
        drive_left(1'b1, 32'hD8, 1'b0, 1'b0);
        drive_right(1'b1, 32'hD9, 1'b0, 1'b0);
        settle;
        chk("t3_both_ltready", l_tready, 1);
        chk("t3_both_rtready", r_tready, 1);
        tick;
        drive_left(1'b0, '0, 1'b0, 1'b0);
        drive_right(1'b0, '0, 1'b0, 1'b0);
        settle;
        chk("t3_dropcnt5", drop_cnt, 5);
        tick;

        // ---------------- 3-line left frame with random backpressure
        cfg_frame_lines = 12'd3;
        drive_left(1'b1, 32'hE000_0000, 1'b1, 1'b0);
        settle;
        tick;
        k = 0;
        cyc = 0;
        while (k < 6 && cyc < 200) begin
            m_tready = 1'($urandom_range(0, 1));
            drive_left(1'b1, 32'hE000_0000 + k, (k == 0), (k % 2 == 1));
            drive_right(1'b1, 32'hF0, 1'b0, 1'b0);
            settle;
            chk("t4_mvalid", m_tvalid, 1);
            chk("t4_mdata", m_tdata, 32'hE000_0000 + k);
            chk("t4_ltready_mirror", l_tready, m_tready);
            chk("t4_rtready", r_tready, 0);
            chk("t4_fdone_mid", frame_done, 0);
            if (m_tready) k++;
            cyc++;
            tick;
        end
        chk("t4_all_beats", k, 6);
        drive_left(1'b0, '0, 1'b0, 1'b0);
        drive_right(1'b0, '0, 1'b0, 1'b0);
        m_tready = 1'b1;
        settle;
        chk("t4_fdone", frame_done, 1);
        chk("t4_no_drop", drop_cnt, 5);
        tick;

        // ---------------- cfg=0 behaves as one line
        cfg_frame_lines = 12'd0;
        drive_left(1'b1, 32'h6000, 1'b1, 1'b0);
        settle;
        tick;
        settle;
        chk("t5_data0", m_tdata, 32'h6000);
        tick;
        drive_left(1'b1, 32'h6001, 1'b0, 1'b1);
        settle;
        chk("t5_fdone_mid", frame_done, 0);
        tick;
        drive_left(1'b0, '0, 1'b0, 1'b0);
        settle;
        chk("t5_fdone", frame_done, 1);
        chk("t5_end_mvalid", m_tvalid, 0);
        tick;

        // ---------------- cfg change mid-frame ignored
        cfg_frame_lines = 12'd2;
        drive_left(1'b1, 32'h7000, 1'b1, 1'b1);
        settle;
        tick;
        cfg_frame_lines = 12'd5;
        settle;
        chk("t6_data0", m_tdata, 32'h7000);
        tick;
        drive_left(1'b1, 32'h7001, 1'b0, 1'b1);
        settle;
        chk("t6_mvalid", m_tvalid, 1);
        chk("t6_fdone_mid", frame_done, 0);
        tick;
        drive_left(1'b0, '0, 1'b0, 1'b0);
        settle;
        chk("t6_fdone", frame_done, 1);
        chk("t6_end_mvalid", m_tvalid, 0);
        tick;

        // ---------------- async reset mid-line of a right frame
        cfg_frame_lines = 12'd2;
        drive_right(1'b1, 32'h8000, 1'b1, 1'b0);
        settle;
        tick;
        settle;
        chk("t7_grant_tdest", m_tdest, 1);
        chk("t7_grant_data", m_tdata, 32'h8000);
        tick;
        drive_right(1'b1, 32'h8001, 1'b0, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t7_rst_mvalid", m_tvalid, 0);
        chk("t7_rst_rtready", r_tready, 0);
        chk("t7_rst_ltready", l_tready, 0);
        chk("t7_rst_tdest", m_tdest, 0);
        drive_right(1'b0, '0, 1'b0, 1'b0);
        settle;
        aresetn = 1'b1;
        tick;
        drive_left(1'b1, 32'h9000, 1'b1, 1'b0);
        settle;
        chk("t7_post_idle_mvalid", m_tvalid, 0);
        tick;
        settle;
        chk("t7_post_mvalid", m_tvalid, 1);
        chk("t7_post_tdest", m_tdest, 0);
        chk("t7_post_data", m_tdata, 32'h9000);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
